// File: rtl/mult4u_residue_guard.sv
// ============================================================================
// Module   : mult4u_residue_guard
// Purpose  : Handshaked wrapper around a 4x4 unsigned combinational
//            multiplier. It drives registered operands, samples the product
//            after a settle window, checks it against a mod-3 residue of the
//            operands, re-samples on mismatch and flags persistent errors.
// Options  : `define MULT4U_RESIDUE15_EN to add a mod-15 residue check,
//            which also catches product errors that are multiples of 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult4u_residue_guard #(
    parameter int SETTLE_CYCLES = 1,   // 1..15
    parameter int MAX_RETRY     = 2,   // 0..7
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_p,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [3:0] c_settle_m1 = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] c_max_retry = 3'(MAX_RETRY);

    state_t           state_q,     state_d;
    logic             in_ready_q,  in_ready_d;
    logic [3:0]       mul_a_q,     mul_a_d;
    logic [3:0]       mul_b_q,     mul_b_d;
    logic [7:0]       p_q,         p_d;
    logic [3:0]       settle_q,    settle_d;
    logic [2:0]       retry_q,     retry_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_p_q,     out_p_d;
    logic             out_err_q,   out_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic [1:0] w_a_m3;
    logic [1:0] w_b_m3;
    logic [3:0] w_ab_m3_prod;
    logic [1:0] w_r_exp;
    logic [1:0] w_r_got;
    logic       w_mismatch;

    // mod-3 residues of the held operands and of the sampled product
    always_comb begin
        w_a_m3       = 2'(mul_a_q % 4'd3);
        w_b_m3       = 2'(mul_b_q % 4'd3);
        w_ab_m3_prod = {2'b00, w_a_m3} * {2'b00, w_b_m3};
        w_r_exp      = 2'(w_ab_m3_prod % 4'd3);
        w_r_got      = 2'(p_q % 8'd3);
    end

`ifdef MULT4U_RESIDUE15_EN
    logic [3:0] w_a_m15;
    logic [3:0] w_b_m15;
    logic [7:0] w_ab_m15_prod;
    logic [3:0] w_r15_exp;
    logic [3:0] w_r15_got;

    // mod-15 residues; either residue disagreeing counts as a mismatch
    always_comb begin
        w_a_m15       = 4'(mul_a_q % 4'd15);
        w_b_m15       = 4'(mul_b_q % 4'd15);
        w_ab_m15_prod = {4'b0000, w_a_m15} * {4'b0000, w_b_m15};
        w_r15_exp     = 4'(w_ab_m15_prod % 8'd15);
        w_r15_got     = 4'(p_q % 8'd15);
        w_mismatch    = (w_r_exp != w_r_got) || (w_r15_exp != w_r15_got);
    end
`else
    // mod-3 check only
    always_comb begin
        w_mismatch = (w_r_exp != w_r_got);
    end
`endif

    // Next-state and next-output logic for the four-state controller
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        p_d         = p_q;
        settle_d    = settle_q;
        retry_d     = retry_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mul_a_d    = in_a;
                    mul_b_d    = in_b;
                    retry_d    = 3'd0;
                    settle_d   = c_settle_m1;
                    in_ready_d = 1'b0;
                    state_d    = S_DRIVE;
                end
            end

            S_DRIVE: begin
                // Operands stay put; the product is sampled on the final cycle
                if (settle_q == 4'd0) begin
                    p_d     = mul_p;
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end

            S_CHECK: begin
                if (!w_mismatch) begin
                    out_p_d   = p_q;
                    out_err_d = 1'b0;
                    state_d   = S_OUT;
                end else if (retry_q < c_max_retry) begin
                    retry_d  = retry_q + 3'd1;
                    settle_d = c_settle_m1;
                    state_d  = S_DRIVE;
                end else begin
                    out_p_d   = p_q;
                    out_err_d = 1'b1;
                    if (err_count_q != {CNT_W{1'b1}}) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    state_d   = S_OUT;
                end
            end

            S_OUT: begin
                // out_valid is a registered image of this state, so it rises
                // one cycle after the decision and drops on the handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            mul_a_q     <= 4'd0;
            mul_b_q     <= 4'd0;
            p_q         <= 8'd0;
            settle_q    <= 4'd0;
            retry_q     <= 3'd0;
            out_valid_q <= 1'b0;
            out_p_q     <= 8'd0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            p_q         <= p_d;
            settle_q    <= settle_d;
            retry_q     <= retry_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mult4u_residue_guard.sv
// ============================================================================
// Module   : tb_mult4u_residue_guard
// Purpose  : Directed self-checking bench for mult4u_residue_guard with a
//            behavioural multiplier whose output can be overridden to inject
//            persistent or transient product faults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult4u_residue_guard;

    localparam int SETTLE = 1;
    localparam int MAXR   = 2;
    localparam int CW     = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_a = 4'd0;
    logic [3:0]    in_b = 4'd0;
    logic [3:0]    mul_a;
    logic [3:0]    mul_b;
    logic [7:0]    mul_p;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_p;
    logic          out_err;
    logic [CW-1:0] err_count;

    logic          fault_en  = 1'b0;
    logic [7:0]    fault_val = 8'd0;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    mult4u_residue_guard #(
        .SETTLE_CYCLES (SETTLE),
        .MAX_RETRY     (MAXR),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier with fault override
    always_comb begin
        mul_p = fault_en ? fault_val : ({4'b0000, mul_a} * {4'b0000, mul_b});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [3:0] a, input logic [3:0] b);
        int k;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_p"},     32'(out_p),     32'd0);
        check({tag, "_out_err"},   32'(out_err),   32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_mul_a"},     32'(mul_a),     32'd0);
        check({tag, "_mul_b"},     32'(mul_b),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check_reset_state("rst");

        // 15*15 with a correct multiplier
        accept(4'd15, 4'd15);
        wait_valid(n);
        check("t1_lat",   32'(n),         32'd3);
        check("t1_p",     32'(out_p),     32'd225);
        check("t1_err",   32'(out_err),   32'd0);
        check("t1_cnt",   32'(err_count), 32'd0);
        take();
        check("t1_drop",  32'(out_valid), 32'd0);
        check("t1_ready", 32'(in_ready),  32'd1);

        // Persistent fault 226: three samples, then error
        fault_en  = 1'b1;
        fault_val = 8'd226;
        accept(4'd15, 4'd15);
        wait_valid(n);
        check("t2_lat", 32'(n),         32'd7);
        check("t2_p",   32'(out_p),     32'd226);
        check("t2_err", 32'(out_err),   32'd1);
        check("t2_cnt", 32'(err_count), 32'd1);
        take();
        fault_en = 1'b0;

        // Transient fault on the first sample of 7*9
        fault_en  = 1'b1;
        fault_val = 8'd64;
        in_a      = 4'd7;
        in_b      = 4'd9;
        in_valid  = 1'b1;
        check("t3_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        fault_en = 1'b0;
        wait_valid(n);
        check("t3_lat", 32'(n + 1),     32'd5);
        check("t3_p",   32'(out_p),     32'd63);
        check("t3_err", 32'(out_err),   32'd0);
        check("t3_cnt", 32'(err_count), 32'd1);
        take();

        // Backpressure with the next operand already waiting
        accept(4'd2, 4'd3);
        wait_valid(n);
        check("t4_lat", 32'(n), 32'd3);
        in_a     = 4'd4;
        in_b     = 4'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_stall_ready", 32'(in_ready),  32'd0);
            check("t4_stall_valid", 32'(out_valid), 32'd1);
            check("t4_stall_p",     32'(out_p),     32'd6);
            check("t4_stall_mula",  32'(mul_a),     32'd2);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_hs_valid", 32'(out_valid), 32'd0);
        check("t4_hs_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        check("t4_mula2", 32'(mul_a), 32'd4);
        wait_valid(n);
        check("t4_lat2", 32'(n),     32'd3);
        check("t4_p2",   32'(out_p), 32'd20);
        take();

        // +3 error on 5*6, invisible to mod 3 alone
        fault_en  = 1'b1;
        fault_val = 8'd33;
        accept(4'd5, 4'd6);
        wait_valid(n);
        check("t5_p", 32'(out_p), 32'd33);
`ifdef MULT4U_RESIDUE15_EN
        check("t5_lat", 32'(n),         32'd7);
        check("t5_err", 32'(out_err),   32'd1);
        check("t5_cnt", 32'(err_count), 32'd2);
`else
        check("t5_lat", 32'(n),         32'd3);
        check("t5_err", 32'(out_err),   32'd0);
        check("t5_cnt", 32'(err_count), 32'd1);
`endif
        take();
        fault_en = 1'b0;

        // Reset during the DRIVE phase of a retry
        fault_en  = 1'b1;
        fault_val = 8'd226;
        accept(4'd15, 4'd15);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("t6");
        fault_en = 1'b0;
        accept(4'd3, 4'd4);
        wait_valid(n);
        check("t6_lat", 32'(n),         32'd3);
        check("t6_p",   32'(out_p),     32'd12);
        check("t6_err", 32'(out_err),   32'd0);
        check("t6_cnt", 32'(err_count), 32'd0);
        take();

        // Zero operand boundary
        accept(4'd0, 4'd15);
        wait_valid(n);
        check("t7_lat", 32'(n),       32'd3);
        check("t7_p",   32'(out_p),   32'd0);
        check("t7_err", 32'(out_err), 32'd0);
        take();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
